branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/bp_pkg.sv | 25 ++
 rtl/pred_fifo.sv | 47 ++++
 rtl/branch_resolve_unit.sv | 108 ++++++++++
 tb/tb_branch_resolve_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and widths for the branch resolve path: the prediction queue
// entry and the next-PC helper used by both predicted and actual paths.
package bp_pkg;

   localparam int XLEN    = 32;
   localparam int GHR_W   = 7;
   localparam int INDEX_W = 7;
   localparam int TAG_W   = 25;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  target;
      logic             taken;
      logic             hit;
      logic [GHR_W-1:0] ghr;
   } pred_entry_t;

   // Sequential PC wraps modulo 2^32.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc,
                                                input logic            redirect,
                                                input logic [XLEN-1:0] target);
      return redirect ? target : pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue: oldest-first storage with read/write pointers
// and an occupancy count; clear empties it and drops any same-edge push.
module pred_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  pred_entry_t      wr_data,
   output pred_entry_t      rd_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   pred_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the oldest in-flight prediction against the execute outcome,
// trains the predictor and issues a redirect with repaired history on mispredict.
module branch_resolve_unit
   import bp_pkg::XLEN, bp_pkg::TAG_W, bp_pkg::INDEX_W, bp_pkg::pred_entry_t, bp_pkg::next_pc;
#(
   parameter int DEPTH = 8,
   parameter int GHR_W = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pred_valid,
   input  logic [XLEN-1:0]         pred_pc,
   input  logic [XLEN-1:0]         pred_target,
   input  logic                    pred_taken,
   input  logic                    pred_hit,
   input  logic [GHR_W-1:0]        pred_ghr,
   output logic                    pred_ready,
   input  logic                    res_valid,
   output logic                    res_ready,
   input  logic                    res_is_branch,
   input  logic                    res_taken,
   input  logic [XLEN-1:0]         res_target,
   output logic                    upd_valid,
   output logic                    upd_branch,
   output logic                    upd_taken,
   output logic [XLEN-1:0]         upd_target,
   output logic [TAG_W-1:0]        upd_tag,
   output logic [INDEX_W-1:0]      upd_index,
   output logic                    flush,
   output logic [XLEN-1:0]         flush_pc,
   output logic [GHR_W-1:0]        flush_ghr,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic [15:0]             mispredict_cnt
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             push;
   logic             pop;
   logic             mispredict;
   logic             act_taken;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  pred_next;
   logic [XLEN-1:0]  act_next;
   pred_entry_t      wr_entry;
   pred_entry_t      head;

   // Intake stalls for the redirect cycle so fetch can restart on the flush PC.
   assign pred_ready = (count < CNT_W'(DEPTH)) && !flush;
   assign res_ready  = (count != '0);
   assign occupancy  = count;
   assign push       = pred_valid && pred_ready;
   assign pop        = res_valid && res_ready;

   assign wr_entry = '{pc: pred_pc, target: pred_target, taken: pred_taken,
                       hit: pred_hit, ghr: pred_ghr};

   assign act_taken  = res_is_branch && res_taken;
   assign pred_next  = next_pc(head.pc, head.taken && head.hit, head.target);
   assign act_next   = next_pc(head.pc, act_taken, res_target);
   assign mispredict = pop && (pred_next != act_next);

   pred_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_pred_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .clear   (mispredict),
      .wr_data (wr_entry),
      .rd_data (head),
      .count   (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         upd_valid      <= 1'b0;
         upd_branch     <= 1'b0;
         upd_taken      <= 1'b0;
         upd_target     <= '0;
         upd_tag        <= '0;
         upd_index      <= '0;
         flush          <= 1'b0;
         flush_pc       <= '0;
         flush_ghr      <= '0;
         mispredict_cnt <= '0;
      end else begin
         upd_valid <= pop;
         flush     <= mispredict;
         if (pop) begin
            upd_branch <= res_is_branch;
            upd_taken  <= act_taken;
            upd_target <= res_target;
            upd_tag    <= head.pc[XLEN-1:INDEX_W];
            upd_index  <= head.pc[INDEX_W-1:0];
         end
         if (mispredict) begin
            flush_pc  <= act_next;
            // Snapshot predated this branch: shift in its real outcome.
            flush_ghr <= {act_taken, head.ghr[GHR_W-1:1]};
            if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue model predicts every update
// and redirect, and a negedge monitor compares them as the DUT emits them.
module tb_branch_resolve_unit;

   localparam int DEPTH = 8;
   localparam int GHR_W = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_valid, pred_taken, pred_hit, pred_ready;
   logic [31:0] pred_pc, pred_target;
   logic [6:0]  pred_ghr;
   logic        res_valid, res_ready, res_is_branch, res_taken;
   logic [31:0] res_target;
   logic        upd_valid, upd_branch, upd_taken;
   logic [31:0] upd_target;
   logic [24:0] upd_tag;
   logic [6:0]  upd_index;
   logic        flush;
   logic [31:0] flush_pc;
   logic [6:0]  flush_ghr;
   logic [3:0]  occupancy;
   logic [15:0] mispredict_cnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target),
      .pred_taken(pred_taken), .pred_hit(pred_hit), .pred_ghr(pred_ghr),
      .pred_ready(pred_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_is_branch(res_is_branch),
      .res_taken(res_taken), .res_target(res_target),
      .upd_valid(upd_valid), .upd_branch(upd_branch), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_tag(upd_tag), .upd_index(upd_index),
      .flush(flush), .flush_pc(flush_pc), .flush_ghr(flush_ghr),
      .occupancy(occupancy), .mispredict_cnt(mispredict_cnt)
   );

   typedef struct {
      logic        pv;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
      logic        hit;
      logic [6:0]  ghr;
      logic        rv;
      logic        rbr;
      logic        rtk;
      logic [31:0] rtgt;
   } stim_t;

   typedef struct {
      logic        branch;
      logic        taken;
      logic [31:0] target;
      logic [24:0] tag;
      logic [6:0]  index;
      logic        flush;
      logic [31:0] fpc;
      logic [6:0]  fghr;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
      logic        hit;
      logic [6:0]  ghr;
   } ment_t;

   exp_t        exp_q[$];
   ment_t       mq[$];
   logic        m_flush;
   logic [15:0] m_cnt;
   int          n_run = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_run++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic stim_t idle_s();
      stim_t s;
      s = '{pv: 1'b0, pc: 32'h0, tgt: 32'h0, tk: 1'b0, hit: 1'b0, ghr: 7'h0,
            rv: 1'b0, rbr: 1'b0, rtk: 1'b0, rtgt: 32'h0};
      return s;
   endfunction

   function automatic stim_t push_s(input logic [31:0] pc, input logic [31:0] tgt,
                                    input logic tk, input logic hit, input logic [6:0] ghr);
      stim_t s;
      s = idle_s();
      s.pv = 1'b1; s.pc = pc; s.tgt = tgt; s.tk = tk; s.hit = hit; s.ghr = ghr;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      pred_valid = s.pv; pred_pc = s.pc; pred_target = s.tgt;
      pred_taken = s.tk; pred_hit = s.hit; pred_ghr = s.ghr;
      res_valid = s.rv; res_is_branch = s.rbr; res_taken = s.rtk; res_target = s.rtgt;
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input stim_t s);
      logic        m_pr, do_push, do_pop, mis;
      logic [31:0] pn, an;
      ment_t       h;
      exp_t        e;
      m_pr = (mq.size() < DEPTH) && !m_flush;
      chk("pred_ready", 32'(pred_ready), 32'(m_pr));
      chk("res_ready", 32'(res_ready), 32'(mq.size() != 0));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
      apply(s);
      do_push = s.pv && m_pr;
      do_pop  = s.rv && (mq.size() != 0);
      mis     = 1'b0;
      if (do_pop) begin
         h  = mq.pop_front();
         pn = (h.tk && h.hit) ? h.tgt : h.pc + 32'd4;
         an = (s.rbr && s.rtk) ? s.rtgt : h.pc + 32'd4;
         mis = (pn != an);
         e.branch = s.rbr;
         e.taken  = s.rbr && s.rtk;
         e.target = s.rtgt;
         e.tag    = h.pc[31:7];
         e.index  = h.pc[6:0];
         e.flush  = mis;
         e.fpc    = an;
         e.fghr   = {e.taken, h.ghr[6:1]};
         if (mis) begin
            mq.delete();
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
      end
      if (do_push && !mis) mq.push_back('{pc: s.pc, tgt: s.tgt, tk: s.tk, hit: s.hit, ghr: s.ghr});
      m_flush = mis;
      @(posedge clk);
      if (do_pop) exp_q.push_back(e);
      #1;
      apply(idle_s());
   endtask

   task automatic do_reset(input stim_t s);
      apply(s);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(idle_s());
      mq.delete();
      m_flush = 1'b0;
      m_cnt   = 16'h0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (upd_valid || flush || exp_q.size() != 0)) begin
         if (exp_q.size() == 0) begin
            chk("spurious_upd", {30'd0, upd_valid, flush}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("upd_valid", 32'(upd_valid), 32'd1);
            chk("upd_branch", 32'(upd_branch), 32'(e.branch));
            chk("upd_taken", 32'(upd_taken), 32'(e.taken));
            chk("upd_target", upd_target, e.target);
            chk("upd_tag", 32'(upd_tag), 32'(e.tag));
            chk("upd_index", 32'(upd_index), 32'(e.index));
            chk("flush", 32'(flush), 32'(e.flush));
            if (e.flush) begin
               chk("flush_pc", flush_pc, e.fpc);
               chk("flush_ghr", 32'(flush_ghr), 32'(e.fghr));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired, bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t       s;
      logic        rbr_a [8];
      logic        rtk_a [8];
      logic [31:0] rtgt_a [8];
      logic [31:0] pc, tg;
      logic [31:0] tset [3];

      rst = 1'b1;
      m_flush = 1'b0;
      m_cnt = 16'h0;
      apply(idle_s());
      do_reset(idle_s());

      // reset state
      chk("rst_pred_ready", 32'(pred_ready), 32'd1);
      chk("rst_res_ready", 32'(res_ready), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_upd_valid", 32'(upd_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_cnt", 32'(mispredict_cnt), 32'd0);
      chk("rst_upd_target", upd_target, 32'd0);
      chk("rst_flush_pc", flush_pc, 32'd0);

      // correctly predicted taken branch
      step(push_s(32'h100, 32'h200, 1'b1, 1'b1, 7'h00));
      s = idle_s(); s.rv = 1'b1; s.rbr = 1'b1; s.rtk = 1'b1; s.rtgt = 32'h200;
      step(s);
      chk("v1_upd_valid", 32'(upd_valid), 32'd1);
      chk("v1_upd_index", 32'(upd_index), 32'h00);
      chk("v1_upd_tag", 32'(upd_tag), 32'h2);
      chk("v1_flush", 32'(flush), 32'd0);

      // predicted not-taken, actually taken
      step(push_s(32'h104, 32'h0, 1'b0, 1'b1, 7'h55));
      s = idle_s(); s.rv = 1'b1; s.rbr = 1'b1; s.rtk = 1'b1; s.rtgt = 32'h300;
      step(s);
      chk("v2_flush", 32'(flush), 32'd1);
      chk("v2_flush_pc", flush_pc, 32'h300);
      chk("v2_flush_ghr", 32'(flush_ghr), 32'h6A);
      chk("v2_cnt", 32'(mispredict_cnt), 32'd1);
      step(idle_s());
      step(idle_s());

      // fill to full with four prediction patterns that all resolve correctly
      for (int i = 0; i < 8; i++) begin
         pc = 32'h2000 + 32'(i) * 32'h40;
         case (i % 4)
            0: begin step(push_s(pc, 32'h3000 + 32'(i) * 32'h10, 1'b1, 1'b1, 7'(i)));
                     rbr_a[i] = 1'b1; rtk_a[i] = 1'b1; rtgt_a[i] = 32'h3000 + 32'(i) * 32'h10; end
            1: begin step(push_s(pc, 32'h0, 1'b0, 1'b0, 7'(i)));
                     rbr_a[i] = 1'b0; rtk_a[i] = 1'b1; rtgt_a[i] = 32'h5555; end
            2: begin step(push_s(pc, 32'h9000, 1'b1, 1'b0, 7'(i)));
                     rbr_a[i] = 1'b1; rtk_a[i] = 1'b0; rtgt_a[i] = 32'h9000; end
            default: begin step(push_s(pc, pc + 32'd4, 1'b1, 1'b1, 7'(i)));
                     rbr_a[i] = 1'b1; rtk_a[i] = 1'b0; rtgt_a[i] = 32'hABC0; end
         endcase
      end
      chk("full_pred_ready", 32'(pred_ready), 32'd0);
      step(push_s(32'h4000, 32'h0, 1'b0, 1'b0, 7'h0));
      chk("full_ninth_occ", 32'(occupancy), 32'd8);
      s = push_s(32'h4004, 32'h0, 1'b0, 1'b0, 7'h0);
      s.rv = 1'b1; s.rbr = rbr_a[0]; s.rtk = rtk_a[0]; s.rtgt = rtgt_a[0];
      step(s);
      chk("full_pushpop_occ", 32'(occupancy), 32'd7);
      for (int i = 1; i < 8; i++) begin
         s = idle_s(); s.rv = 1'b1; s.rbr = rbr_a[i]; s.rtk = rtk_a[i]; s.rtgt = rtgt_a[i];
         step(s);
      end

      // mispredict with a push offered on the same edge
      step(push_s(32'h6000, 32'h7000, 1'b1, 1'b1, 7'h11));
      step(push_s(32'h6004, 32'h0, 1'b0, 1'b0, 7'h22));
      step(push_s(32'h6008, 32'h0, 1'b0, 1'b0, 7'h33));
      s = push_s(32'h600C, 32'h0, 1'b0, 1'b0, 7'h44);
      s.rv = 1'b1; s.rbr = 1'b0; s.rtk = 1'b0; s.rtgt = 32'h0;
      step(s);
      chk("mis_occ", 32'(occupancy), 32'd0);
      chk("mis_pred_ready", 32'(pred_ready), 32'd0);
      step(idle_s());
      chk("post_flush_ready", 32'(pred_ready), 32'd1);

      // resolve while empty, then reset with five entries in flight
      s = idle_s(); s.rv = 1'b1; s.rbr = 1'b1; s.rtk = 1'b1; s.rtgt = 32'h1234;
      step(s);
      chk("empty_res_upd", 32'(upd_valid), 32'd0);
      for (int i = 0; i < 5; i++) step(push_s(32'h8000 + 32'(i) * 4, 32'h0, 1'b0, 1'b0, 7'h0));
      s = push_s(32'h9000, 32'h0, 1'b0, 1'b0, 7'h0);
      s.rv = 1'b1; s.rbr = 1'b1; s.rtk = 1'b1; s.rtgt = 32'h100;
      do_reset(s);
      chk("rst5_occ", 32'(occupancy), 32'd0);
      chk("rst5_upd_valid", 32'(upd_valid), 32'd0);
      chk("rst5_flush", 32'(flush), 32'd0);
      chk("rst5_pred_ready", 32'(pred_ready), 32'd1);

      // random traffic, including a PC at the top of the address space
      tset[0] = 32'h0; tset[1] = 32'h400; tset[2] = 32'h800;
      for (int n = 0; n < 300; n++) begin
         pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         tg = tset[$urandom_range(0, 2)];
         s = push_s(pc, tg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom));
         s.pv   = 1'($urandom_range(0, 1));
         s.rv   = ($urandom_range(0, 2) == 0);
         s.rbr  = 1'($urandom_range(0, 1));
         s.rtk  = 1'($urandom_range(0, 1));
         s.rtgt = tset[$urandom_range(0, 2)];
         step(s);
      end
      step(idle_s());
      step(idle_s());

      // counter saturation from a preloaded value
      force dut.mispredict_cnt = 16'hFFFE;
      #4;
      release dut.mispredict_cnt;
      m_cnt = 16'hFFFE;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         step(push_s(32'hA000, 32'h0, 1'b0, 1'b1, 7'h7F));
         s = idle_s(); s.rv = 1'b1; s.rbr = 1'b1; s.rtk = 1'b1; s.rtgt = 32'hB000;
         step(s);
         chk("sat_cnt", 32'(mispredict_cnt), 32'hFFFF);
         step(idle_s());
      end

      @(negedge clk);
      #1;
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
